kd_search: RTL and testbench
============================

# kd_search

Nearest-center query engine for the kd-tree of cluster centers. The compare-exchange sorting network writes and orders the tree; this block reads it. It accepts one point, walks the heap-ordered tree through a synchronous-read node port, and computes the Manhattan distance at every visited node. It returns the index, center and distance of the closest center found, feeding the point-assignment stage of k-means.

## Interface
- `dim`, default 3: coordinates per point. The axis cycles 0..dim-1 by tree level.
- `data_range`, default 255: maximum coordinate value. `dim_size = $clog2(data_range)` = 8.
- `depth`, default 3: tree levels. Node count `N = 2**depth - 1`. Root is node 0; children of node i are 2i+1 (left) and 2i+2 (right).
- Derived widths:
  - `center_size = dim*dim_size` = 24
  - `dist_size = $clog2(data_range*dim)` = 10
  - `idx_size = $clog2(N)`, minimum 1
- `clk`, in, 1: the single clock. All state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: `point_in` is valid.
- `in_ready`, out, 1: high only in IDLE.
- `point_in`, in, `center_size`: query point. Coordinate d is at bits `[d*dim_size +: dim_size]`.
- `node_addr`, out, `idx_size`: tree read address.
- `node_data`, in, `center_size`: center stored at `node_addr`, valid one cycle after the address is driven.
- `out_valid`, out, 1: result valid. Held until it is accepted.
- `out_ready`, in, 1: result accepted when `out_valid && out_ready`.
- `best_idx`, out, `idx_size`: index of the nearest node.
- `best_center`, out, `center_size`: center of the nearest node.
- `best_dst`, out, `dist_size`: Manhattan distance from the point to `best_center`.

## Operation
- States: IDLE, FETCH, EVAL, POP, DONE. POP exists only with backtracking compiled in.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`: latch `point_in`; set cur = 0, level = 0, `best_dst` = all-ones; clear the stack; go to FETCH.
- FETCH: drive `node_addr` = cur; go to EVAL.
- EVAL:
  - Compute dst = Σ|p_d − c_d| over all coordinates, zero-extended to `dist_size`.
  - If dst < `best_dst` (strictly less), update best. On a tie, the earlier-visited node wins.
  - axis = level mod dim.
  - Go left if p_axis ≤ c_axis, otherwise go right.
  - Not a leaf (level < depth−1): cur = chosen child, level += 1, go to FETCH.
  - Leaf: go to DONE, or to POP with backtracking.
- DONE:
  - `out_valid` = 1; outputs are stable while `out_ready` is low.
  - On handshake: go to IDLE. `in_ready` rises the next cycle.
- `in_valid` while busy is ignored. The point is not consumed.
- Arithmetic:
  - Per-coordinate absolute differences are unsigned, `dim_size` bits.
  - The sum cannot overflow `dist_size`.
- Reset, including mid-query:
  - State = IDLE, `in_ready` = 1.
  - `out_valid` = 0, `node_addr` = 0, `best_idx` = 0, `best_center` = 0, `best_dst` = 0, stack empty.
  - The in-flight query is dropped and produces no result.

## Timing
- The accept edge is T0.
- Greedy mode: FETCH/EVAL alternate, 2 cycles per level. `out_valid` rises at edge T0 + 2·depth.
- `node_addr` is registered. `node_data` is sampled in EVAL, one cycle after FETCH.
- Backtracking mode:
  - Each EVAL at a leaf goes to POP.
  - Each POP takes 1 cycle.
  - Each revisited subtree adds 2 cycles per node.

## Configuration
- `KD_SEARCH_BACKTRACK_EN` defined:
  - A stack of depth−1 entries holds {sibling idx, sibling level, plane distance |p_axis − c_axis|}.
  - Every non-leaf EVAL pushes the unchosen child.
  - POP with an empty stack goes to DONE.
  - POP otherwise pops one entry. If plane < `best_dst`, set cur and level from the entry and go to FETCH. Otherwise stay in POP.
  - The result is the exact nearest center.
- `KD_SEARCH_BACKTRACK_EN` undefined: no stack and no POP state. Single greedy descent; the result is approximate.

## Structure
- Package `kd_pkg`:
  - Width functions/constants: `dim_size`, `center_size`, `dist_size`, `axis_size`, `idx_size`.
  - State encodings.
  - Coordinate-slice helper.
  - These are shared with the sorting network.
- Sub-module `kd_node_dist`: combinational; takes (point, center, axis) and returns dst and axis plane distance.

## Test plan
Tree for all cases: depth = 2, dim = 3, node0 = (100,100,100), node1 = (50,20,20), node2 = (200,90,90).
- Point (60,30,30):
  - Path 0→1.
  - Result: `best_idx` = 1, `best_dst` = 30.
  - `out_valid` at T0+4 (greedy) or T0+6 (backtrack: node2 pruned, since 40 ≥ 30).
- Point (100,100,100):
  - Tie rule sends the walk left.
  - Result: `best_idx` = 0, `best_dst` = 0.
  - The node1 distance of 210 does not replace the best.
- Point (101,0,0):
  - Greedy: path 0→2; `best_idx` = 0, `best_dst` = 201.
  - Backtrack: node1 revisited (plane 1 < 201); `best_idx` = 1, `best_dst` = 91, `out_valid` at T0+8.
- Hold `out_ready` = 0 for 5 cycles:
  - Outputs stay stable and `in_ready` stays 0.
  - A new `in_valid` during this time is not accepted.
- Assert `rst` during the EVAL cycle of node1:
  - All outputs go to their reset values immediately.
  - No `out_valid` appears.
  - The next query completes normally.

Source files
------------

// File: rtl/kd_pkg.sv
// kd_pkg: widths, state codes and slice helper for the kd-tree blocks.
// Shared by kd_search and the compare-exchange sorting network.
package kd_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_POP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic int clog2_min1(int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int dim_size(int range);
    return $clog2(range);
  endfunction

  function automatic int center_size(int dim, int range);
    return dim * dim_size(range);
  endfunction

  function automatic int dist_size(int dim, int range);
    return $clog2(range * dim);
  endfunction

  function automatic int axis_size(int dim);
    return clog2_min1(dim);
  endfunction

  function automatic int idx_size(int depth);
    return clog2_min1((1 << depth) - 1);
  endfunction

  function automatic int lvl_size(int depth);
    return clog2_min1(depth);
  endfunction

  // LSB of coordinate d inside a packed point/center vector
  function automatic int coord_lsb(int d, int ds);
    return d * ds;
  endfunction

endpackage

// File: rtl/kd_node_dist.sv
// kd_node_dist: Manhattan distance of a point to one center,
// plus plane distance and branch direction on the split axis.
module kd_node_dist
  import kd_pkg::*;
#(
  parameter int dim = 3,
  parameter int data_range = 255,
  localparam int DS = dim_size(data_range),
  localparam int CS = center_size(dim, data_range),
  localparam int DT = dist_size(dim, data_range),
  localparam int AW = axis_size(dim)
) (
  input  logic [CS-1:0] point_i,
  input  logic [CS-1:0] center_i,
  input  logic [AW-1:0] axis_i,
  output logic [DT-1:0] dst_o,
  output logic [DS-1:0] plane_o,
  output logic          left_o
);

  // sum of per-coordinate absolute differences
  always_comb begin
    logic [DS-1:0] p;
    logic [DS-1:0] c;
    logic [DS-1:0] ad;
    dst_o   = '0;
    plane_o = '0;
    left_o  = 1'b1;
    p       = '0;
    c       = '0;
    ad      = '0;
    for (int d = 0; d < dim; d++) begin
      p     = point_i[coord_lsb(d, DS) +: DS];
      c     = center_i[coord_lsb(d, DS) +: DS];
      ad    = (p > c) ? (p - c) : (c - p);
      dst_o = dst_o + DT'(ad);
      if (axis_i == AW'(d)) begin
        plane_o = ad;
        left_o  = (p <= c);
      end
    end
  end

endmodule

// File: rtl/kd_search.sv
// kd_search: nearest-center walk over a heap-ordered kd-tree.
// Define KD_SEARCH_BACKTRACK_EN for exact search with a sibling stack.
module kd_search
  import kd_pkg::*;
#(
  parameter int dim = 3,
  parameter int data_range = 255,
  parameter int depth = 3,
  localparam int DS = dim_size(data_range),
  localparam int CS = center_size(dim, data_range),
  localparam int DT = dist_size(dim, data_range),
  localparam int AW = axis_size(dim),
  localparam int IW = idx_size(depth),
  localparam int LW = lvl_size(depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CS-1:0] point_in,
  output logic [IW-1:0] node_addr,
  input  logic [CS-1:0] node_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] best_idx,
  output logic [CS-1:0] best_center,
  output logic [DT-1:0] best_dst
);

  logic [2:0]    state_q, state_d;
  logic [CS-1:0] pt_q, pt_d;
  logic [IW-1:0] cur_q, cur_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [IW-1:0] bidx_q, bidx_d;
  logic [CS-1:0] bctr_q, bctr_d;
  logic [DT-1:0] bdst_q, bdst_d;

  logic [AW-1:0] axis;
  logic [DT-1:0] dst;
  logic [DS-1:0] plane;
  logic          go_left;
  logic          leaf;
  logic [IW-1:0] lchild;
  logic [IW-1:0] rchild;

  assign axis   = AW'(int'(lvl_q) % dim);
  assign leaf   = (int'(lvl_q) == depth - 1);
  assign lchild = IW'(2 * int'(cur_q) + 1);
  assign rchild = IW'(2 * int'(cur_q) + 2);

  kd_node_dist #(
    .dim        (dim),
    .data_range (data_range)
  ) u_dist (
    .point_i  (pt_q),
    .center_i (node_data),
    .axis_i   (axis),
    .dst_o    (dst),
    .plane_o  (plane),
    .left_o   (go_left)
  );

`ifdef KD_SEARCH_BACKTRACK_EN
  localparam int SD = (depth > 1) ? depth - 1 : 1;
  localparam int SW = clog2_min1(SD + 1);

  logic [SW-1:0] sp_q, sp_d;
  logic [IW-1:0] stk_idx_q [2**SW];
  logic [LW-1:0] stk_lvl_q [2**SW];
  logic [DS-1:0] stk_pln_q [2**SW];
  logic          push;
  logic [SW-1:0] top;

  assign top = sp_q - SW'(1);

  // sibling stack storage; only the pointer needs a reset
  always_ff @(posedge clk) begin
    if (push) begin
      stk_idx_q[sp_q] <= go_left ? rchild : lchild;
      stk_lvl_q[sp_q] <= lvl_q + LW'(1);
      stk_pln_q[sp_q] <= plane;
    end
  end

  // stack pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end
`else
  logic [DS-1:0] unused_plane;
  assign unused_plane = plane;
`endif

  // next-state and datapath control
  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    cur_d   = cur_q;
    lvl_d   = lvl_q;
    bidx_d  = bidx_q;
    bctr_d  = bctr_q;
    bdst_d  = bdst_q;
`ifdef KD_SEARCH_BACKTRACK_EN
    sp_d    = sp_q;
    push    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pt_d    = point_in;
          cur_d   = '0;
          lvl_d   = '0;
          bdst_d  = '1;
`ifdef KD_SEARCH_BACKTRACK_EN
          sp_d    = '0;
`endif
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_EVAL;
      S_EVAL: begin
        if (dst < bdst_q) begin
          bidx_d = cur_q;
          bctr_d = node_data;
          bdst_d = dst;
        end
        if (!leaf) begin
          cur_d   = go_left ? lchild : rchild;
          lvl_d   = lvl_q + LW'(1);
          state_d = S_FETCH;
`ifdef KD_SEARCH_BACKTRACK_EN
          push    = 1'b1;
          sp_d    = sp_q + SW'(1);
`endif
        end else begin
`ifdef KD_SEARCH_BACKTRACK_EN
          state_d = S_POP;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef KD_SEARCH_BACKTRACK_EN
      S_POP: begin
        if (sp_q == '0) begin
          state_d = S_DONE;
        end else begin
          sp_d = top;
          if (DT'(stk_pln_q[top]) < bdst_q) begin
            cur_d   = stk_idx_q[top];
            lvl_d   = stk_lvl_q[top];
            state_d = S_FETCH;
          end
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pt_q    <= '0;
      cur_q   <= '0;
      lvl_q   <= '0;
      bidx_q  <= '0;
      bctr_q  <= '0;
      bdst_q  <= '0;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      cur_q   <= cur_d;
      lvl_q   <= lvl_d;
      bidx_q  <= bidx_d;
      bctr_q  <= bctr_d;
      bdst_q  <= bdst_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign node_addr   = cur_q;
  assign best_idx    = bidx_q;
  assign best_center = bctr_q;
  assign best_dst    = bdst_q;

endmodule

// File: tb/tb_kd_search.sv
// tb_kd_search: directed checks of kd_search on a depth-2 tree.
// Expectations follow KD_SEARCH_BACKTRACK_EN when it is defined.
module tb_kd_search;

  localparam logic [23:0] N0 = {8'd100, 8'd100, 8'd100};
  localparam logic [23:0] N1 = {8'd20, 8'd20, 8'd50};
  localparam logic [23:0] N2 = {8'd90, 8'd90, 8'd200};
  localparam logic [23:0] PA = {8'd30, 8'd30, 8'd60};
  localparam logic [23:0] PB = {8'd100, 8'd100, 8'd100};
  localparam logic [23:0] PC = {8'd0, 8'd0, 8'd101};

`ifdef KD_SEARCH_BACKTRACK_EN
  localparam int L1 = 6;
  localparam int L2 = 6;
  localparam int L3 = 8;
  localparam int I3 = 1;
  localparam int D3 = 91;
  localparam logic [23:0] C3 = N1;
`else
  localparam int L1 = 4;
  localparam int L2 = 4;
  localparam int L3 = 4;
  localparam int I3 = 0;
  localparam int D3 = 201;
  localparam logic [23:0] C3 = N0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] point_in = '0;
  logic [23:0] node_data;
  logic [23:0] best_center;
  logic [1:0]  node_addr;
  logic [1:0]  best_idx;
  logic [9:0]  best_dst;
  logic [23:0] mem [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // synchronous-read tree memory
  always @(posedge clk) node_data <= mem[node_addr];

  kd_search #(
    .dim        (3),
    .data_range (255),
    .depth      (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .point_in    (point_in),
    .node_addr   (node_addr),
    .node_data   (node_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .best_idx    (best_idx),
    .best_center (best_center),
    .best_dst    (best_dst)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ov(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [23:0] p,
                     input int e_idx, input int e_dst,
                     input logic [23:0] e_ctr, input int e_lat);
    int cyc;
    @(negedge clk);
    point_in = p;
    in_valid = 1'b1;
    chk({tag, ".rdy_in"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_ov(cyc);
    chk({tag, ".lat"}, 32'(cyc), 32'(e_lat));
    chk({tag, ".idx"}, 32'(best_idx), 32'(e_idx));
    chk({tag, ".dst"}, 32'(best_dst), 32'(e_dst));
    chk({tag, ".ctr"}, 32'(best_center), 32'(e_ctr));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".ov_clr"}, 32'(out_valid), 32'd0);
    chk({tag, ".rdy_out"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    int seen;
    mem[0] = N0;
    mem[1] = N1;
    mem[2] = N2;
    mem[3] = '0;

    repeat (2) @(negedge clk);
    chk("rst.rdy", 32'(in_ready), 32'd1);
    chk("rst.ov", 32'(out_valid), 32'd0);
    chk("rst.dst", 32'(best_dst), 32'd0);
    chk("rst.addr", 32'(node_addr), 32'd0);
    rst = 1'b0;

    run("near", PA, 1, 30, N1, L1);
    run("tie", PB, 0, 0, N0, L2);
    run("far", PC, I3, D3, C3, L3);

    // result held under back-pressure, new point ignored
    @(negedge clk);
    point_in = PC;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_ov(cyc);
    chk("hold.lat", 32'(cyc), 32'(L3));
    for (int i = 0; i < 5; i++) begin
      point_in = PA;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("hold.ov", 32'(out_valid), 32'd1);
      chk("hold.rdy", 32'(in_ready), 32'd0);
      chk("hold.idx", 32'(best_idx), 32'(I3));
      chk("hold.dst", 32'(best_dst), 32'(D3));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid || !in_ready) seen++;
      @(negedge clk);
    end
    chk("hold.idle", 32'(seen), 32'd0);

    // reset during the EVAL of node1
    point_in = PA;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid.addr1", 32'(node_addr), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid.ov", 32'(out_valid), 32'd0);
    chk("mid.rdy", 32'(in_ready), 32'd1);
    chk("mid.addr", 32'(node_addr), 32'd0);
    chk("mid.idx", 32'(best_idx), 32'd0);
    chk("mid.ctr", 32'(best_center), 32'd0);
    chk("mid.dst", 32'(best_dst), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("mid.no_ov", 32'(seen), 32'd0);

    run("after", PA, 1, 30, N1, L1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
